// File: rtl/decoder_7seg_to_bin_frame.sv
`default_nettype none
// ============================================================================
// Module   : decoder_7seg_to_bin_frame
// Brief    : Decodes a stream of 7-segment glyphs into a DIGITS-nibble frame;
//            optional macro DECODER_7SEG_BLANK_EN accepts blank (00) as 0.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_7seg_to_bin_frame #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [6:0]            segments_in,
    input  logic                  seg_valid_in,
    output logic                  seg_ready_out,
    input  logic                  flush_in,
    output logic [4*DIGITS-1:0]   value_out,
    output logic [DIGITS-1:0]     invalid_mask_out,
    output logic                  error_out,
    output logic                  value_valid_out,
    input  logic                  value_ready_in
);

    localparam int c_VW = 4 * DIGITS;
    localparam int c_CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [0:0] {
        S_COLLECT = 1'b0,
        S_HOLD    = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_CW-1:0]      r_count;
    logic [c_VW-1:0]      r_shadow;
    logic [DIGITS-1:0]    r_shadow_mask;

    logic [3:0]           w_nib;
    logic                 w_bad;
    logic                 w_accept;
    logic [c_VW-1:0]      w_shadow_next;
    logic [DIGITS-1:0]    w_mask_next;

    always_comb begin
        w_nib = 4'h0;
        w_bad = 1'b0;
        case (segments_in)
            7'h3F: w_nib = 4'h0;
            7'h06: w_nib = 4'h1;
            7'h5B: w_nib = 4'h2;
            7'h4F: w_nib = 4'h3;
            7'h66: w_nib = 4'h4;
            7'h6D: w_nib = 4'h5;
            7'h7D: w_nib = 4'h6;
            7'h07: w_nib = 4'h7;
            7'h7F: w_nib = 4'h8;
            7'h6F: w_nib = 4'h9;
            7'h77: w_nib = 4'hA;
            7'h7C: w_nib = 4'hB;
            7'h39: w_nib = 4'hC;
            7'h5E: w_nib = 4'hD;
            7'h79: w_nib = 4'hE;
            7'h71: w_nib = 4'hF;
`ifdef DECODER_7SEG_BLANK_EN
            7'h00: w_nib = 4'h0;
`endif
            default: w_bad = 1'b1;
        endcase
    end

    assign w_accept      = seg_valid_in & seg_ready_out;
    // New glyph enters at the LSB so the first glyph ends up most significant.
    assign w_shadow_next = c_VW'({r_shadow, w_nib});
    assign w_mask_next   = DIGITS'({r_shadow_mask, w_bad});

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state          <= S_COLLECT;
            r_count          <= '0;
            r_shadow         <= '0;
            r_shadow_mask    <= '0;
            value_out        <= '0;
            invalid_mask_out <= '0;
            error_out        <= 1'b0;
            value_valid_out  <= 1'b0;
            seg_ready_out    <= 1'b0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    seg_ready_out <= 1'b1;
                    if (flush_in) begin
                        r_count       <= '0;
                        r_shadow      <= '0;
                        r_shadow_mask <= '0;
                    end else if (w_accept) begin
                        if (r_count == c_CW'(DIGITS - 1)) begin
                            value_out        <= w_shadow_next;
                            invalid_mask_out <= w_mask_next;
                            error_out        <= |w_mask_next;
                            value_valid_out  <= 1'b1;
                            seg_ready_out    <= 1'b0;
                            r_state          <= S_HOLD;
                            r_count          <= '0;
                            r_shadow         <= '0;
                            r_shadow_mask    <= '0;
                        end else begin
                            r_shadow      <= w_shadow_next;
                            r_shadow_mask <= w_mask_next;
                            r_count       <= r_count + c_CW'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (value_ready_in) begin
                        value_valid_out <= 1'b0;
                        seg_ready_out   <= 1'b1;
                        r_state         <= S_COLLECT;
                        r_count         <= '0;
                        r_shadow        <= '0;
                        r_shadow_mask   <= '0;
                    end
                end
                default: r_state <= S_COLLECT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decoder_7seg_to_bin_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_7seg_to_bin_frame
// Brief    : Directed and random checks of the glyph-to-frame decoder against a
//            queue-based frame model (honours DECODER_7SEG_BLANK_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_7seg_to_bin_frame;

    localparam int DIGITS = 4;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [6:0]          segments_in = '0;
    logic                seg_valid_in = 1'b0;
    logic                seg_ready_out;
    logic                flush_in = 1'b0;
    logic [4*DIGITS-1:0] value_out;
    logic [DIGITS-1:0]   invalid_mask_out;
    logic                error_out;
    logic                value_valid_out;
    logic                value_ready_in = 1'b0;

    int n_total = 0;
    int n_bad   = 0;

    decoder_7seg_to_bin_frame #(.DIGITS(DIGITS)) u_dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .segments_in      (segments_in),
        .seg_valid_in     (seg_valid_in),
        .seg_ready_out    (seg_ready_out),
        .flush_in         (flush_in),
        .value_out        (value_out),
        .invalid_mask_out (invalid_mask_out),
        .error_out        (error_out),
        .value_valid_out  (value_valid_out),
        .value_ready_in   (value_ready_in)
    );

    always #5 clk = ~clk;

    // Glyph for each hex digit, indexed by the digit value.
    logic [6:0] glyph_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Frame-level model: queued nibbles of the frame in progress plus last frame.
    int                  m_nibs [$];
    bit                  m_bads [$];
    bit                  m_ready;
    bit                  m_valid;
    logic [4*DIGITS-1:0] m_value;
    logic [DIGITS-1:0]   m_mask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void ref_decode(input logic [6:0] p, output int nib, output bit bad);
        nib = 0;
        bad = 1'b1;
        for (int i = 0; i < 16; i++)
            if (glyph_tbl[i] == p) begin
                nib = i;
                bad = 1'b0;
            end
`ifdef DECODER_7SEG_BLANK_EN
        if (p == 7'h00) bad = 1'b0;
`endif
    endfunction

    function automatic void model_step();
        int nib;
        bit bad;
        if (!reset_n) begin
            m_nibs.delete();
            m_bads.delete();
            m_ready = 0;
            m_valid = 0;
            m_value = '0;
            m_mask  = '0;
        end else if (!m_valid) begin
            bit acc = seg_valid_in && m_ready;
            m_ready = 1;
            if (flush_in) begin
                m_nibs.delete();
                m_bads.delete();
            end else if (acc) begin
                ref_decode(segments_in, nib, bad);
                m_nibs.push_back(nib);
                m_bads.push_back(bad);
                if (m_nibs.size() == DIGITS) begin
                    m_value = '0;
                    m_mask  = '0;
                    for (int i = 0; i < DIGITS; i++) begin
                        m_value = m_value * 16 + (4*DIGITS)'(m_nibs[i]);
                        m_mask  = m_mask * 2 + DIGITS'(m_bads[i]);
                    end
                    m_nibs.delete();
                    m_bads.delete();
                    m_valid = 1;
                    m_ready = 0;
                end
            end
        end else if (value_ready_in) begin
            m_valid = 0;
            m_ready = 1;
        end
    endfunction

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("valid", 32'(value_valid_out), 32'(m_valid));
        chk("ready", 32'(seg_ready_out), 32'(m_ready));
        chk("value", 32'(value_out), 32'(m_value));
        chk("mask", 32'(invalid_mask_out), 32'(m_mask));
        chk("error", 32'(error_out), 32'(|m_mask));
    endtask

    // Offer one glyph until the model says it was taken (bounded).
    task automatic send(input logic [6:0] p);
        bit taken;
        segments_in  = p;
        seg_valid_in = 1'b1;
        taken = 0;
        for (int k = 0; k < 20 && !taken; k++) begin
            taken = m_ready && !m_valid && !flush_in;
            cyc();
        end
        if (!taken) chk("send_timeout", 32'd0, 32'd1);
        seg_valid_in = 1'b0;
    endtask

    initial begin
        m_ready = 0; m_valid = 0; m_value = '0; m_mask = '0;

        // Reset held for three cycles, then ready appears on the first cycle out.
        repeat (3) cyc();
        reset_n = 1'b1;
        cyc();
        chk("ready_after_reset", 32'(seg_ready_out), 32'd1);

        // Back-to-back frame with consumer always ready.
        value_ready_in = 1'b1;
        send(7'h06); send(7'h5B); send(7'h4F); send(7'h66);
        chk("frame_1234", 32'(value_out), 32'h1234);
        chk("frame_1234_valid", 32'(value_valid_out), 32'd1);
        cyc();
        chk("frame_1234_one_cycle", 32'(value_valid_out), 32'd0);

        // Frame with a blank glyph, held by the consumer; glyph offered during HOLD.
        value_ready_in = 1'b0;
        send(7'h7C); send(7'h39); send(7'h00); send(7'h71);
        chk("frame_bc0f", 32'(value_out), 32'hBC0F);
`ifdef DECODER_7SEG_BLANK_EN
        chk("frame_bc0f_mask", 32'(invalid_mask_out), 32'h0);
        chk("frame_bc0f_err", 32'(error_out), 32'd0);
`else
        chk("frame_bc0f_mask", 32'(invalid_mask_out), 32'h2);
        chk("frame_bc0f_err", 32'(error_out), 32'd1);
`endif
        segments_in  = 7'h3F;
        seg_valid_in = 1'b1;
        flush_in     = 1'b1;
        repeat (5) cyc();
        chk("hold_no_accept", 32'(seg_ready_out), 32'd0);
        flush_in       = 1'b0;
        seg_valid_in   = 1'b0;
        value_ready_in = 1'b1;
        cyc();

        // Flush colliding with a beat discards the partial frame and the beat.
        send(7'h3F); send(7'h3F);
        segments_in = 7'h07; seg_valid_in = 1'b1; flush_in = 1'b1;
        cyc();
        flush_in = 1'b0; seg_valid_in = 1'b0;
        send(7'h07); send(7'h6F); send(7'h77); send(7'h79);
        chk("frame_79ae", 32'(value_out), 32'h79AE);
        cyc();

        // Reset mid-frame leaves no stale nibbles.
        send(7'h7F); send(7'h7F);
        reset_n = 1'b0; cyc();
        reset_n = 1'b1; cyc();
        send(7'h7F); send(7'h7F); send(7'h7F); send(7'h7F);
        chk("frame_8888", 32'(value_out), 32'h8888);
        chk("frame_8888_mask", 32'(invalid_mask_out), 32'h0);
        cyc();

        // Every pattern once, packed four to a frame.
        for (int p = 0; p < 128; p++) send(7'(p));
        cyc();

        // Random traffic with flushes, back-pressure and occasional resets.
        for (int n = 0; n < 4000; n++) begin
            reset_n        = ($urandom_range(0, 299) != 0);
            flush_in       = ($urandom_range(0, 24) == 0);
            value_ready_in = $urandom_range(0, 1);
            seg_valid_in   = $urandom_range(0, 1);
            segments_in    = $urandom_range(0, 1) ? glyph_tbl[$urandom_range(0, 15)]
                                                  : 7'($urandom_range(0, 127));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
